// File: rtl/traceback_scheduler.sv
// traceback_scheduler: Needleman-Wunsch traceback sequencer from (N,N) to (0,0).
// Optional TB_STEP_CNT_EN adds a step_cnt output counting accepted ops.
module traceback_scheduler #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               ram_rd_en,
  output logic [BitAddr:0]   ram_addr_i,
  output logic [BitAddr:0]   ram_addr_j,
  input  logic [2:0]         ram_symbol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_op,
  output logic [BitAddr:0]   out_i,
  output logic [BitAddr:0]   out_j
`ifdef TB_STEP_CNT_EN
  ,
  output logic [BitAddr+1:0] step_cnt
`endif
);
  localparam int W  = BitAddr + 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [W-1:0] NI = W'(N);
  localparam logic [1:0] OP_DIAG = 2'b00, OP_UP = 2'b01, OP_LEFT = 2'b10;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN, ERROR} state_t;
  state_t state, state_n;
  logic [W-1:0] i, j, i_n, j_n, si, sj;
  logic [1:0] op, op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic err_n, sel;
  always_comb begin
    state_n = state;
    i_n = i;
    j_n = j;
    op_n = op;
    cnt_n = cnt;
    err_n = err;
    sel = 1'b0;
    si = i;
    sj = j;
    case (state)
      IDLE: if (start) begin
        sel = 1'b1;
        si = NI;
        sj = NI;
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (cnt == CW'(RD_LAT - 1)) begin
        state_n = (ram_symbol == 3'b000) ? ERROR : EMIT;
        err_n = err | (ram_symbol == 3'b000);
        op_n = ram_symbol[0] ? OP_DIAG : ram_symbol[1] ? OP_UP : OP_LEFT;
      end else cnt_n = cnt + CW'(1);
      EMIT: if (out_ready) begin
        sel = 1'b1;
        si = i - W'(op != OP_LEFT);
        sj = j - W'(op != OP_UP);
      end
      FIN: state_n = IDLE;
      default: ;
    endcase
    // Shared SELECT: boundary cells force a move without touching the RAM
    if (sel) begin
      i_n = si;
      j_n = sj;
      state_n = (si == '0 && sj == '0) ? FIN : (si == '0 || sj == '0) ? EMIT : ISSUE;
      op_n = (si == '0) ? OP_LEFT : (sj == '0) ? OP_UP : op_n;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      i <= NI;
      j <= NI;
      op <= OP_DIAG;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      i <= i_n;
      j <= j_n;
      op <= op_n;
      cnt <= cnt_n;
      err <= err_n;
    end
  end
`ifdef TB_STEP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || (state == IDLE && start)) step_cnt <= '0;
    else if (state == EMIT && out_ready) step_cnt <= step_cnt + (BitAddr + 2)'(1);
  end
`endif
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign ram_rd_en = state == ISSUE;
  assign out_valid = state == EMIT;
  assign ram_addr_i = ram_rd_en ? i - W'(1) : '0;
  assign ram_addr_j = ram_rd_en ? j - W'(1) : '0;
  assign out_op = op;
  assign out_i = out_valid ? i : '0;
  assign out_j = out_valid ? j : '0;
endmodule

// File: tb/tb_traceback_scheduler.sv
// tb_traceback_scheduler: randomized and directed checks of traceback_scheduler
// against a path-walking reference model and a latency-accurate RAM model.
module tb_traceback_scheduler;
  localparam int N = 4, RD_LAT = 2, BA = $clog2(N + 1), W = BA + 1;
  logic clk = 0, rst = 0, start = 0, out_ready = 1;
  logic busy, done, err, ram_rd_en, out_valid;
  logic [W-1:0] ram_addr_i, ram_addr_j, out_i, out_j;
  logic [2:0] ram_symbol;
  logic [1:0] out_op;
`ifdef TB_STEP_CNT_EN
  logic [W:0] step_cnt;
`endif
  int cmp = 0, mism = 0;
  logic [2:0] mem [N][N];
  logic [2:0] pipe [RD_LAT];
  typedef struct packed {logic [1:0] op; logic [W-1:0] i; logic [W-1:0] j;} op_t;
  op_t exp_ops[$];
  int exp_rd[$];
  int exp_cyc, exp_nops;

  traceback_scheduler #(.N(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .ram_rd_en(ram_rd_en), .ram_addr_i(ram_addr_i), .ram_addr_j(ram_addr_j),
    .ram_symbol(ram_symbol), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_i(out_i), .out_j(out_j)
`ifdef TB_STEP_CNT_EN
    , .step_cnt(step_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Direction RAM: data appears RD_LAT cycles after the read strobe
  always @(posedge clk) begin
    pipe[0] <= ram_rd_en ? mem[int'(ram_addr_i)][int'(ram_addr_j)] : 3'b000;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_symbol = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        mem[a][b] = (v == 0) ? 3'($urandom_range(7, 1)) : 3'(v);
  endtask

  // Reference: walk the path from (N,N) using the traceback rules directly
  task automatic build_model();
    int i = N, j = N, op;
    logic [2:0] s;
    exp_ops.delete();
    exp_rd.delete();
    exp_cyc = 0;
    while (i > 0 || j > 0) begin
      if (i == 0) begin
        op = 2; exp_cyc += 1;
      end else if (j == 0) begin
        op = 1; exp_cyc += 1;
      end else begin
        s = mem[i-1][j-1];
        op = s[0] ? 0 : s[1] ? 1 : 2;
        exp_rd.push_back(((i - 1) << W) | (j - 1));
        exp_cyc += RD_LAT + 2;
      end
      exp_ops.push_back({2'(op), W'(i), W'(j)});
      if (op != 2) i--;
      if (op != 1) j--;
    end
    exp_nops = exp_ops.size();
  endtask

  task automatic run(input int pct, input int hold, input bit timed);
    int cyc, held = 0, e;
    bit stall = 0;
    op_t prev;
    build_model();
    @(negedge clk) start = 1;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (out_valid && held < hold) begin
        out_ready = 0;
        held++;
      end else out_ready = ($urandom_range(99) < pct);
      chk("busy_run", busy, 1);
      if (stall) begin
        chk("stall_hold", {out_valid, out_op, out_i, out_j}, {1'b1, prev});
        chk("stall_no_rd", ram_rd_en, 0);
      end
      if (ram_rd_en) begin
        e = exp_rd.size() > 0 ? exp_rd.pop_front() : -1;
        chk("rd_addr", 32'((ram_addr_i << W) | ram_addr_j), e);
      end
      if (out_valid && out_ready)
        chk("op_ij", {out_op, out_i, out_j}, exp_ops.size() > 0 ? exp_ops.pop_front() : '1);
      stall = out_valid && !out_ready;
      prev = {out_op, out_i, out_j};
      start = done ? 1'b0 : ($urandom_range(9) == 0);
      if (done) break;
    end
    start = 0;
    out_ready = 1;
    chk("done_seen", cyc <= 400, 1);
    chk("ops_left", exp_ops.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("err_run", err, 0);
    if (timed) chk("done_cycle", cyc, exp_cyc + 1 + hold);
`ifdef TB_STEP_CNT_EN
    chk("step_cnt", step_cnt, exp_nops);
`endif
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int p, k;
    fill(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {busy, done, err, ram_rd_en, out_valid}, 0);
    chk("rst_addr", {ram_addr_i, ram_addr_j}, 0);
    chk("rst_out", {out_op, out_i, out_j}, 0);
`ifdef TB_STEP_CNT_EN
    chk("rst_step", step_cnt, 0);
`endif
    rst = 1;
    fill(3'b001); run(100, 0, 1);
    chk("diag_cycles", exp_cyc, 16);
    fill(3'b010); run(100, 0, 1);
    chk("up_nops", exp_nops, 8);
    fill(3'b001); run(100, 5, 1);
    fill(3'b011); run(100, 0, 1);
    fill(3'b110); run(100, 0, 1);
    for (int r = 0; r < 20; r++) begin
      fill(0);
      p = (r % 2) ? 100 : $urandom_range(100, 30);
      run(p, $urandom_range(3), p == 100);
    end
    // Illegal symbol on the second read
    fill(3'b001); mem[2][2] = 3'b000;
    @(negedge clk) start = 1;
    for (k = 0; k < 60 && !err; k++) begin
      @(negedge clk) start = 0;
    end
    chk("err_seen", err, 1);
    chk("err_cycle", k, 2 * (RD_LAT + 2));
    for (int c = 0; c < 6; c++) begin
      start = (c == 1);
      @(negedge clk);
      chk("err_hold", {err, busy, out_valid, ram_rd_en, done}, 5'b11000);
    end
    start = 0;
    rst = 0;
    @(negedge clk);
    chk("err_rst", {err, busy, out_valid}, 0);
    rst = 1;
    // Reset during WAIT, then a clean rerun
    fill(3'b001);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("mid_rd", ram_rd_en, 1);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("mid_rst", {busy, out_valid, ram_rd_en, done, err}, 0);
    rst = 1;
    run(100, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
